// File: rtl/cjb_risc_hmmiop_cu_v.sv
// Control unit for the 8-bit Harvard RISC with memory-mapped I/O-Ps.
// Moore FSM sequencing fetch/decode/execute; strobes decode from state and IW.
module cjb_risc_hmmiop_cu_v (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] IW,
  input  logic [3:0] SR_CNVZ,
  output logic       RST_PC,
  output logic       LD_PC,
  output logic       CNT_PC,
  output logic       LD_IR,
  output logic       LD_R0,
  output logic       LD_R1,
  output logic       LD_R2,
  output logic       LD_R3,
  output logic       LD_SR,
  output logic       LD_MABR,
  output logic       LD_MAXR,
  output logic       LD_MAR,
  output logic       RW,
  output logic       LD_IPDR,
  output logic       LD_OPDR,
  output logic       push,
  output logic       pop,
  output logic       ipstksel,
  output logic [1:0] IB0_SEL,
  output logic [1:0] IB1_SEL,
  output logic [1:0] IB2_SEL,
  output logic [3:0] ALU_FS,
  output logic       Halted
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_MEM1, S_MEM2, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_op;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic       w_br_taken;
  logic [3:0] w_ld_r;

  assign w_op       = IW[7:4];
  assign w_ra       = IW[3:2];
  assign w_rb       = IW[1:0];
  assign w_br_taken = |(SR_CNVZ & IW[3:0]);

  assign LD_R0 = w_ld_r[0];
  assign LD_R1 = w_ld_r[1];
  assign LD_R2 = w_ld_r[2];
  assign LD_R3 = w_ld_r[3];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    RST_PC   = 1'b0;
    LD_PC    = 1'b0;
    CNT_PC   = 1'b0;
    LD_IR    = 1'b0;
    w_ld_r   = '0;
    LD_SR    = 1'b0;
    LD_MABR  = 1'b0;
    LD_MAXR  = 1'b0;
    LD_MAR   = 1'b0;
    RW       = 1'b0;
    LD_IPDR  = 1'b0;
    LD_OPDR  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    ipstksel = 1'b0;
    IB0_SEL  = '0;
    IB1_SEL  = '0;
    IB2_SEL  = '0;
    ALU_FS   = '0;
    Halted   = 1'b0;
    case (r_state)
      S_RST: begin
        RST_PC = 1'b1;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        LD_IR  = 1'b1;
        CNT_PC = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          4'h1, 4'h2, 4'hC, 4'hD: begin
            // Offset byte is consumed even for a not-taken branch; the MABR/MAXR loads are harmless.
            CNT_PC  = 1'b1;
            LD_MABR = 1'b1;
            LD_MAXR = 1'b1;
            IB0_SEL = w_rb;
            IB2_SEL = 2'b00;
            w_next  = (w_op == 4'hC && !w_br_taken) ? S_FETCH : S_MEM1;
          end
          4'hF:    w_next = S_HALT;
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op) inside
          4'h3: begin
            IB0_SEL = w_rb;
            IB2_SEL = 2'b00;
            w_ld_r  = 4'b0001 << w_ra;
          end
          [4'h4:4'hB]: begin
            ALU_FS  = w_op;
            IB0_SEL = w_ra;
            IB1_SEL = w_rb;
            IB2_SEL = 2'b01;
            w_ld_r  = 4'b0001 << w_ra;
            LD_SR   = 1'b1;
          end
          4'hE: begin
            case (w_ra)
              2'b00: begin
                IB0_SEL = w_rb;
                IB2_SEL = 2'b00;
                push    = 1'b1;
              end
              2'b01: begin
                ipstksel = 1'b1;
                IB2_SEL  = 2'b11;
                pop      = 1'b1;
                w_ld_r   = 4'b0001 << w_rb;
              end
              2'b10: begin
                LD_IPDR = 1'b1;
                w_next  = S_EXEC2;
              end
              default: begin
                IB0_SEL = w_rb;
                IB2_SEL = 2'b00;
                LD_OPDR = 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        ipstksel = 1'b0;
        IB2_SEL  = 2'b11;
        w_ld_r   = 4'b0001 << w_rb;
        w_next   = S_FETCH;
      end
      S_MEM1: begin
        LD_MAR = 1'b1;
        w_next = S_MEM2;
      end
      S_MEM2: begin
        case (w_op)
          4'h1: begin
            IB2_SEL = 2'b10;
            w_ld_r  = 4'b0001 << w_ra;
          end
          4'h2: begin
            IB0_SEL = w_ra;
            IB2_SEL = 2'b00;
            RW      = 1'b1;
          end
          4'hC, 4'hD: LD_PC = 1'b1;
          default: ;
        endcase
        w_next = S_FETCH;
      end
      S_HALT: Halted = 1'b1;
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: doc/cjb_risc_hmmiop_cu_v.md
Name: cjb_risc_hmmiop_cu_v

Overview:
Control unit (the controller end of the HMMIOP data-path control/status interface) for the 8-bit Harvard RISC with memory-mapped I/O-Ps. It consumes the instruction word and SR flags from the data path. It sequences fetch/decode/execute through a Moore FSM, driving every data-path load, select, stack and memory strobe. Top level = this block + data path, wired port-to-port by name.

Parameters:
None.

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-low reset
IW  input  8  instruction register contents; opcode IW[7:4], Ra IW[3:2], Rb IW[1:0]
SR_CNVZ  input  4  status flags {C,N,V,Z}
RST_PC  output  1  PC reset
LD_PC, CNT_PC  output  1 each  PC load from MAR / PC increment
LD_IR  output  1  IR load from PM
LD_R0, LD_R1, LD_R2, LD_R3  output  1 each  register file loads, one-hot or none
LD_SR  output  1  status register load
LD_MABR, LD_MAXR, LD_MAR  output  1 each  address-path register loads
RW  output  1  DM write enable
LD_IPDR, LD_OPDR  output  1 each  input/output data register loads
push, pop, ipstksel  output  1 each  HW-stack strobes; 1 = stack, 0 = IPDR on bus-2 source 3
IB0_SEL, IB1_SEL, IB2_SEL  output  2 each  internal bus selects
ALU_FS  output  4  ALU function select
Halted  output  1  high while in S_HALT

Behaviour:
- Moore FSM. Outputs decode from state and IW only; no output is registered. Default for every output is 0.
- States: S_RST, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_MEM1, S_MEM2, S_HALT.
- Reset low forces S_RST asynchronously. S_RST: RST_PC=1, all else 0 → S_FETCH.
- S_FETCH: LD_IR=1, CNT_PC=1 → S_DECODE.
- S_DECODE, opcode dependent:
  - Two-word ops (0001 LOAD, 0010 STORE, 1100 BRcc, 1101 JUMP): CNT_PC=1, LD_MABR=1, LD_MAXR=1, IB0_SEL=Rb, IB2_SEL=00. These go to S_MEM1.
  - Exception: BRcc not taken, i.e. (SR_CNVZ & IW[3:0])==0, goes to S_FETCH. Offset byte is skipped; MABR/MAXR loads are harmless.
  - 1111 HALT → S_HALT.
  - All others → S_EXEC.
- S_EXEC:
  - 0000 NOP: no strobes.
  - 0011 MOV: IB0_SEL=Rb, IB2_SEL=00, LD_R[Ra]=1.
  - 0100–1011 ALU: ALU_FS=IW[7:4], IB0_SEL=Ra, IB1_SEL=Rb, IB2_SEL=01, LD_R[Ra]=1, LD_SR=1.
  - 1110 with IW[3:2] sub-op:
    - 00 PUSH: IB0_SEL=Rb, IB2_SEL=00, push=1.
    - 01 POP: ipstksel=1, IB2_SEL=11, pop=1, LD_R[Rb]=1.
    - 10 IN: LD_IPDR=1, then → S_EXEC2.
    - 11 OUT: IB0_SEL=Rb, IB2_SEL=00, LD_OPDR=1.
  - Next state S_FETCH, except IN.
- S_EXEC2 (IN only): ipstksel=0, IB2_SEL=11, LD_R[Rb]=1 → S_FETCH.
- S_MEM1: LD_MAR=1. MAR captures on the falling edge mid-cycle → S_MEM2.
- S_MEM2:
  - LOAD: IB2_SEL=10, LD_R[Ra]=1.
  - STORE: IB0_SEL=Ra, IB2_SEL=00, RW=1.
  - BRcc taken / JUMP: LD_PC=1.
  - → S_FETCH.
- S_HALT: all strobes 0, Halted=1. Exits only via Reset.
- Never assert push and pop together, or CNT_PC and LD_PC together, or more than one LD_Rx.
- Cycle counts:
  - 3 cycles: NOP, MOV, ALU, PUSH, POP, OUT.
  - 4 cycles: IN.
  - 4 cycles: LOAD, STORE, taken branch, JUMP.
  - 2 cycles: not-taken branch.
- Reset asserted mid-instruction aborts immediately. No partial store or register write occurs after Reset falls.

Test Plan:
- Reset low 3 cycles then high → S_RST 1 cycle with RST_PC=1, then LD_IR=1, CNT_PC=1 on the next cycle; Halted=0.
- IW=0x46 (ALU, Ra=R1, Rb=R2) → in S_EXEC: ALU_FS=4'h4, IB0_SEL=01, IB1_SEL=10, IB2_SEL=01, LD_R1=1, LD_SR=1. Instruction takes 3 cycles.
- IW=0x1B (LOAD R2 ← M[base+R3]) → DECODE: LD_MABR=LD_MAXR=CNT_PC=1, IB0_SEL=11. MEM1: LD_MAR=1. MEM2: IB2_SEL=10, LD_R2=1. RW stays 0 throughout.
- IW=0xC1 with SR_CNVZ=4'b0000 → back to S_FETCH after DECODE (2 cycles, LD_PC never 1). Repeat with SR_CNVZ=4'b0001 → LD_MAR then LD_PC in successive cycles.
- IW=0xE8 (IN R0) → EXEC: LD_IPDR=1. EXEC2: ipstksel=0, IB2_SEL=11, LD_R0=1. IW=0xE5 (POP R1) → pop=1, ipstksel=1, LD_R1=1, push=0.
- IW=0x2C (STORE R3) with Reset pulled low during S_MEM1 → RW never asserts; FSM in S_RST. IW=0xF0 → Halted=1, all strobes 0 for 20+ cycles until Reset.
